// File: rtl/latch_exerciser.sv
// Drives a fixed {S,R,en} vector sequence into an external gated SR latch and
// scores the returned Q/nQ against an internally tracked expected latch state.
module latch_exerciser #(
  parameter int unsigned HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       S,
  output logic       R,
  output logic       en,
  input  logic       Q,
  input  logic       nQ,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [3:0] vec_idx
);

  typedef enum logic [1:0] {IDLE, INIT, APPLY, DONE} state_t;

  localparam logic [3:0] LAST_HOLD = 4'(HOLD - 1);
  localparam logic [3:0] LAST_VEC  = 4'd10;

  state_t     state, state_n;
  logic [3:0] hold_cnt, hold_n;
  logic [3:0] idx_n, err_n, err_inc;
  logic       exp_q, exp_n;
  logic       s_n, r_n, en_n, busy_n, done_n, pass_n;
  logic       last_hold, mismatch;
  logic [2:0] drv;

  function automatic logic [2:0] vec_drive(input logic [3:0] idx);
    case (idx)
      4'd0:    vec_drive = 3'b000;
      4'd1:    vec_drive = 3'b010;
      4'd2:    vec_drive = 3'b100;
      4'd3:    vec_drive = 3'b110;
      4'd4:    vec_drive = 3'b101;
      4'd5:    vec_drive = 3'b000;
      4'd6:    vec_drive = 3'b011;
      4'd7:    vec_drive = 3'b001;
      4'd8:    vec_drive = 3'b101;
      4'd9:    vec_drive = 3'b001;
      4'd10:   vec_drive = 3'b101;
      default: vec_drive = 3'b000;
    endcase
  endfunction

  // Expected latch state once a {S,R,en} vector has been applied.
  function automatic logic exp_after(input logic cur, input logic [2:0] d);
    if (d[0] && d[2] && !d[1])      exp_after = 1'b1;
    else if (d[0] && !d[2] && d[1]) exp_after = 1'b0;
    else                            exp_after = cur;
  endfunction

  always_comb begin
    state_n   = state;
    hold_n    = hold_cnt;
    idx_n     = vec_idx;
    err_n     = err_count;
    exp_n     = exp_q;
    s_n       = S;
    r_n       = R;
    en_n      = en;
    busy_n    = busy;
    done_n    = done;
    pass_n    = pass;
    drv       = 3'b000;
    last_hold = (hold_cnt == LAST_HOLD);
    mismatch  = (Q != exp_q) || (nQ != ~exp_q);
    err_inc   = (err_count == 4'hF) ? 4'hF : err_count + 4'd1;

    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = INIT;
          hold_n  = '0;
          idx_n   = '0;
          err_n   = '0;
          exp_n   = 1'b0;
          {s_n, r_n, en_n} = 3'b011;
          busy_n  = 1'b1;
          done_n  = 1'b0;
          pass_n  = 1'b0;
        end
      end
      INIT: begin
        if (last_hold) begin
          if (mismatch) err_n = err_inc;
          state_n = APPLY;
          hold_n  = '0;
          idx_n   = '0;
          drv     = vec_drive(4'd0);
          {s_n, r_n, en_n} = drv;
          exp_n   = exp_after(exp_q, drv);
        end else begin
          hold_n = hold_cnt + 4'd1;
        end
      end
      APPLY: begin
        if (last_hold) begin
          if (mismatch) err_n = err_inc;
          hold_n = '0;
          if (vec_idx == LAST_VEC) begin
            state_n = DONE;
            idx_n   = '0;
            {s_n, r_n, en_n} = 3'b000;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            pass_n  = (err_n == '0);
          end else begin
            // exp_q moves with the vector being launched, not the one just scored
            idx_n = vec_idx + 4'd1;
            drv   = vec_drive(idx_n);
            {s_n, r_n, en_n} = drv;
            exp_n = exp_after(exp_q, drv);
          end
        end else begin
          hold_n = hold_cnt + 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      vec_idx   <= '0;
      err_count <= '0;
      exp_q     <= 1'b0;
      S         <= 1'b0;
      R         <= 1'b0;
      en        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      state     <= state_n;
      hold_cnt  <= hold_n;
      vec_idx   <= idx_n;
      err_count <= err_n;
      exp_q     <= exp_n;
      S         <= s_n;
      R         <= r_n;
      en        <= en_n;
      busy      <= busy_n;
      done      <= done_n;
      pass      <= pass_n;
    end
  end

endmodule

// File: doc/latch_exerciser.md
LATCH_EXERCISER -- requirements
Module: latch_exerciser

Interface
REQ-001 Parameter: HOLD, default 4, number of clk cycles each drive vector is held; legal range 2..15.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  run request; sampled only in IDLE or DONE.
REQ-005 S  output  1  set drive to external gated SR latch.
REQ-006 R  output  1  reset drive to external gated SR latch.
REQ-007 en  output  1  enable drive to external gated SR latch.
REQ-008 Q  input  1  latch true output, returned from DUT.
REQ-009 nQ  input  1  latch complement output, returned from DUT.
REQ-010 busy  output  1  high in INIT and APPLY.
REQ-011 done  output  1  high in DONE.
REQ-012 pass  output  1  high in DONE when err_count==0.
REQ-013 err_count  output  4  mismatch count, saturating at 15.
REQ-014 vec_idx  output  4  index of vector being driven; 0 in INIT, IDLE and DONE.

Function
REQ-015 The FSM SHALL have states IDLE, INIT, APPLY and DONE; S, R, en, busy, done, pass, err_count and vec_idx SHALL all be registered.
REQ-016 IDLE: S=R=en=0; start=1 -> INIT on next edge, clearing err_count, hold counter and vec_idx.
REQ-017 INIT SHALL drive S=0, R=1, en=1 for HOLD cycles, forcing expected state exp_q=0, then go to APPLY with vec_idx=0.
REQ-018 APPLY SHALL drive the fixed 11-entry table {S,R,en}, HOLD cycles per entry: 0:000 1:010 2:100 3:110 4:101 5:000 6:011 7:001 8:101 9:001 10:101.
REQ-019 Reference model exp_q SHALL update at the start of each vector: en=1,S=1,R=0 -> 1; en=1,S=0,R=1 -> 0; S=R=0 or en=0 -> hold; the table never contains en=1 with S=R=1.
REQ-020 Expected Q per vector SHALL be: 0,0,0,0,1,1,0,0,1,1,1.
REQ-021 Compare SHALL occur on the last hold cycle of INIT and of each vector: mismatch if Q!=exp_q or nQ!=~exp_q; each mismatch adds 1 to err_count, which saturates at 15.
REQ-022 After the compare of vector 10, the FSM SHALL enter DONE and drive S=R=en=0.
REQ-023 Total run length SHALL be 12*HOLD cycles, from the first INIT cycle to the first DONE cycle.
REQ-024 DONE SHALL hold done=1, pass and err_count stable until start=1, which restarts at INIT, or until rst.
REQ-025 start during INIT or APPLY SHALL be ignored, with no restart and no counter effect.
REQ-026 Q and nQ SHALL be sampled only on compare cycles; values on other cycles SHALL have no effect.

Reset
REQ-027 rst=1 SHALL, on the next edge, force IDLE with S=R=en=0, busy=done=pass=0, err_count=0, vec_idx=0 and exp_q=0.
REQ-028 rst SHALL take priority over start and over any in-progress run; an aborted run SHALL leave no residual count.
REQ-029 The first cycle after rst deasserts SHALL be IDLE; start may be accepted on that cycle.

Verification
REQ-030 Ideal behavioural gated SR latch connected, HOLD=4, start pulse -> busy for 48 cycles, then done=1, pass=1, err_count=0.
REQ-031 Q tied 0, nQ tied 1 -> mismatches at vectors 4,5,8,9,10 -> err_count=5, pass=0.
REQ-032 Q tied 1, nQ tied 1 -> all 12 compares fail -> err_count=12; then Q=nQ=1 with HOLD=2 and a second start -> restart clears, err_count=12 again.
REQ-033 rst asserted at vector 6 mid-run -> next cycle IDLE, S=R=en=0, err_count=0; a new start runs the full 48 cycles.
REQ-034 start held high throughout a run -> exactly one run, DONE reached at cycle 48, then immediate restart into INIT.
REQ-035 Protocol check on every cycle: S=R=en=1 never driven; vec_idx sequence 0..10 with each value held HOLD cycles.
